// File: rtl/ucsbece154b_icache.sv
// Set-associative read-only instruction cache between fetch and the SDRAM controller.
// Hits return one cycle after the address is accepted; misses refill a whole line, one beat at a time.
module ucsbece154b_icache #(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReadEnable,
    input  logic [ADDR_WIDTH-1:0] ReadAddress,
    output logic [WORD_SIZE-1:0]  Instruction,
    output logic                  Ready,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] MemReadAddress,
    output logic                  MemReadRequest,
    input  logic [WORD_SIZE-1:0]  MemDataIn,
    input  logic                  MemDataReady
);

    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int unsigned LOW_W = OFF_W + 2;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} stateType;

    stateType state, stateNext;

    logic [ADDR_WIDTH-1:2] addrQ;
    logic                  pendingQ;
    logic [OFF_W-1:0]      wordCnt;
    logic                  replValidQ;

    logic [WORD_SIZE-1:0] dataMem  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0]     tagMem   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  validBits[NUM_SETS];
    logic [WAY_W-1:0]     rrPtr    [NUM_SETS];
    logic [WORD_SIZE-1:0] lineBuf  [BLOCK_WORDS];

    logic [OFF_W-1:0]     wordOff;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic [WORD_SIZE-1:0] hitWord;
    logic [WAY_W-1:0]     victimWay;
    logic                 victimValid;
    logic                 lastBeat;
    logic                 beat;
    logic                 accept;
    logic                 unusedByteBits;

    assign unusedByteBits = ^ReadAddress[1:0];
    assign wordOff  = addrQ[OFF_W+1:2];
    assign idx      = addrQ[IDX_W+OFF_W+1:OFF_W+2];
    assign tag      = addrQ[ADDR_WIDTH-1:IDX_W+OFF_W+2];
    assign lastBeat = (wordCnt == OFF_W'(BLOCK_WORDS - 1));
    assign beat     = (state == FILL) && MemDataReady;
    // A new address is taken only once any outstanding miss has been serviced.
    assign accept   = (state == DONE) || ((state == IDLE) && !(pendingQ && !hit));

    always_comb begin
        hit     = 1'b0;
        hitWord = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (validBits[idx][w] && (tagMem[idx][w] == tag)) begin
                hit     = 1'b1;
                hitWord = dataMem[idx][w][wordOff];
            end
        end
    end

    // Lowest-index invalid way wins; a full set falls back to its round-robin pointer.
    always_comb begin
        victimWay   = rrPtr[idx];
        victimValid = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!validBits[idx][w]) begin
                victimWay   = WAY_W'(w);
                victimValid = 1'b0;
            end
        end
    end

    always_comb begin
        stateNext      = state;
        Ready          = 1'b0;
        Instruction    = '0;
        Busy           = 1'b0;
        MemReadRequest = 1'b0;
        MemReadAddress = '0;
        case (state)
            IDLE: begin
                if (pendingQ) begin
                    if (hit) begin
                        Ready       = 1'b1;
                        Instruction = hitWord;
                    end else begin
                        stateNext = REQ;
                    end
                end
            end
            REQ: begin
                Busy           = 1'b1;
                MemReadRequest = 1'b1;
                MemReadAddress = {addrQ[ADDR_WIDTH-1:LOW_W], LOW_W'(0)};
                stateNext      = FILL;
            end
            FILL: begin
                Busy = 1'b1;
                if (MemDataReady && lastBeat) stateNext = DONE;
            end
            DONE: begin
                Ready       = 1'b1;
                Instruction = lineBuf[wordOff];
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addrQ      <= '0;
            pendingQ   <= 1'b0;
            wordCnt    <= '0;
            replValidQ <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                validBits[s] <= '0;
                rrPtr[s]     <= '0;
            end
        end else begin
            state <= stateNext;
            if (accept) begin
                pendingQ <= ReadEnable;
                if (ReadEnable) addrQ <= ReadAddress[ADDR_WIDTH-1:2];
            end
            if (beat) begin
                wordCnt <= wordCnt + OFF_W'(1);
                if (lastBeat) begin
                    validBits[idx][victimWay] <= 1'b1;
                    replValidQ                <= victimValid;
                end
            end
            // Pointer only moves when a refill displaced a valid line.
            if ((state == DONE) && replValidQ) rrPtr[idx] <= rrPtr[idx] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            lineBuf[wordCnt] <= MemDataIn;
            if (lastBeat) begin
                tagMem[idx][victimWay] <= tag;
                for (int w = 0; w < BLOCK_WORDS; w++) begin
                    dataMem[idx][victimWay][w] <= (OFF_W'(w) == wordCnt) ? MemDataIn : lineBuf[w];
                end
            end
        end
    end

endmodule
